// File: rtl/sev_seg_rd_if.sv
// Bundle of segment/anode inputs and decoded outputs for the seven-segment readback block.
// Carries err_cnt only when SEV_SEG_RD_ERRCNT_EN is defined.
interface sev_seg_rd_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic [4*NUM_DIGITS-1:0] hex_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_valid;
  logic                    pat_err;
`ifdef SEV_SEG_RD_ERRCNT_EN
  logic [7:0]              err_cnt;

  modport master (
    output seg_in, an_in,
    input  hex_out, digit_valid, frame_valid, pat_err, err_cnt
  );

  modport slave (
    input  seg_in, an_in,
    output hex_out, digit_valid, frame_valid, pat_err, err_cnt
  );
`else
  modport master (
    output seg_in, an_in,
    input  hex_out, digit_valid, frame_valid, pat_err
  );

  modport slave (
    input  seg_in, an_in,
    output hex_out, digit_valid, frame_valid, pat_err
  );
`endif
endinterface

// File: rtl/sev_seg_rd.sv
// Reads back a multiplexed active-low seven-segment display and recovers the hex nibble per digit.
// Optional SEV_SEG_RD_ERRCNT_EN adds a saturating counter of unmatched captures on bus.err_cnt.
//
// state  | meaning
// IDLE   | synchronized an_in is not one-cold, nothing to track
// SETTLE | one digit selected, counting identical consecutive samples
// HOLD   | window captured, waiting for the sampled inputs to change
module sev_seg_rd #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYC = 4
) (
  input logic         clk,
  input logic         rst_n,
  sev_seg_rd_if.slave bus
);

  localparam int         IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] CNT_LAST  = 8'(STABLE_CYC - 1);
  localparam logic [7:0] CNT_FULL  = 8'(STABLE_CYC);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                  state, state_nx;
  logic [7:0]              cnt, cnt_nx;
  logic                    capture;
  logic [6:0]              seg_m, seg_s, seg_p;
  logic [NUM_DIGITS-1:0]   an_m, an_s, an_p;
  logic                    same, one_cold;
  logic [IW-1:0]           sel;
  logic [4:0]              dec;
  logic [4*NUM_DIGITS-1:0] hex_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic                    frame_q;
  logic                    err_q;

  // Returns {matched, nibble}; anything outside the hex table yields matched=0.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  // seg_p/an_p hold the previous synchronized sample for the stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '1;
      seg_s <= '1;
      seg_p <= '1;
      an_m  <= '1;
      an_s  <= '1;
      an_p  <= '1;
    end else begin
      seg_m <= bus.seg_in;
      seg_s <= seg_m;
      seg_p <= seg_s;
      an_m  <= bus.an_in;
      an_s  <= an_m;
      an_p  <= an_s;
    end
  end

  assign same     = (seg_s == seg_p) && (an_s == an_p);
  assign one_cold = $onehot(~an_s);
  assign dec      = decode(seg_s);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) sel = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (one_cold) begin
          state_nx = SETTLE;
          cnt_nx   = 8'd1;
        end
      end
      SETTLE: begin
        if (!one_cold) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (!same) begin
          cnt_nx = 8'd1;
        end else if (cnt == CNT_LAST) begin
          state_nx = HOLD;
          cnt_nx   = CNT_FULL;
          capture  = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      HOLD: begin
        if (!one_cold) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (!same) begin
          state_nx = SETTLE;
          cnt_nx   = 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // A completed frame clears digit_valid one cycle after the last capture; the
  // FSM is always in HOLD on that edge, so no capture can collide with the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q   <= '0;
      valid_q <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (&valid_q) begin
      frame_q <= 1'b1;
      valid_q <= '0;
    end else begin
      frame_q <= 1'b0;
      if (capture) begin
        if (dec[4]) begin
          hex_q[4*int'(sel) +: 4] <= dec[3:0];
          valid_q[sel]            <= 1'b1;
        end else if (seg_s != SEG_BLANK) begin
          err_q <= 1'b1;
        end
      end
    end
  end

`ifdef SEV_SEG_RD_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (capture && !dec[4] && (seg_s != SEG_BLANK) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.hex_out     = hex_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_valid = frame_q;
  assign bus.pat_err     = err_q;

endmodule

// File: doc/sev_seg_rd.md
SEV_SEG_RD -- requirements
Module: sev_seg_rd

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digit positions (range 1..8).
REQ-002 Parameter STABLE_CYC, default 4, consecutive identical synchronized samples required before capture (range 2..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 seg_in  input  7  active-low segment lines, bit 0 = segment a … bit 6 = segment g.
REQ-006 an_in  input  NUM_DIGITS  active-low digit enables; exactly one low bit selects a digit.
REQ-007 hex_out  output  4*NUM_DIGITS  decoded nibbles, digit i at bits [4i+3:4i].
REQ-008 digit_valid  output  NUM_DIGITS  bit i set once digit i has been captured in the current frame.
REQ-009 frame_valid  output  1  one-cycle pulse when all digit_valid bits become set.
REQ-010 pat_err  output  1  sticky flag: a stable non-blank pattern matched no hex code.

Function
REQ-011 seg_in and an_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Decode SHALL be the exact inverse of the team hex table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (bit 6..0).
REQ-013 FSM states: IDLE (no valid select), SETTLE (counting stability), HOLD (captured, awaiting change).
REQ-014 IDLE->SETTLE when synchronized an_in has exactly one zero bit; counter loads 1.
REQ-015 SETTLE: counter increments while the synchronized {seg,an} equals the previous sample; any difference restarts the counter at 1 (stays SETTLE if still one-cold, else IDLE).
REQ-016 SETTLE->HOLD on the edge where the counter reaches STABLE_CYC; that same edge performs the capture.
REQ-017 Capture, pattern matched: write nibble to the selected slot, set its digit_valid bit.
REQ-018 Capture, pattern 1111111 (blank): no slot or flag update.
REQ-019 Capture, pattern unmatched and non-blank: slot and digit_valid unchanged; pat_err set.
REQ-020 HOLD: no further capture; any change of synchronized {seg,an} -> SETTLE (counter=1) or IDLE (select not one-cold).
REQ-021 an_in with zero or multiple low bits SHALL never capture and SHALL force IDLE.
REQ-022 Latency: input change to hex_out update SHALL be STABLE_CYC+2 cycles.
REQ-023 When a capture makes digit_valid all-ones, frame_valid SHALL pulse on the next cycle and digit_valid SHALL clear on that same cycle; hex_out retains values.
REQ-024 Recapturing an already-valid digit SHALL overwrite its nibble and SHALL NOT produce frame_valid by itself.
REQ-025 pat_err clears only on reset.

Reset
REQ-026 On rst_n low: FSM=IDLE, counter=0, synchronizers=all-ones, hex_out=0, digit_valid=0, frame_valid=0, pat_err=0, immediately and asynchronously.
REQ-027 Reset mid-SETTLE SHALL discard the partial count; no capture may occur from pre-reset samples.

Configuration
REQ-028 Macro SEV_SEG_RD_ERRCNT_EN: when defined, output err_cnt (8 bits) SHALL count unmatched captures, saturating at 255, reset to 0; when undefined, the port and counter are absent and behaviour is otherwise identical.

Verification
REQ-029 Reset, then an_in=1110, seg_in=0100100 held 10 cycles -> hex_out[3:0]=2 at cycle STABLE_CYC+2, digit_valid=0001, exactly one capture.
REQ-030 Scan digits 0..3 with patterns for 1,A,7,F, 8 cycles each -> hex_out=16'hF7A1, frame_valid single pulse, digit_valid=0000 after.
REQ-031 an_in=1110, seg_in toggling every 2 cycles (STABLE_CYC=4) -> no capture, digit_valid=0000.
REQ-032 an_in=1100 with a valid pattern held 20 cycles -> no capture; an_in=1111 -> no capture.
REQ-033 Stable pattern 1010101 on digit 1 -> pat_err=1, hex_out unchanged; with SEV_SEG_RD_ERRCNT_EN, 300 such captures -> err_cnt=255.
REQ-034 rst_n asserted at counter=STABLE_CYC-1 -> all outputs 0 immediately; no capture after release until a fresh full stable window.
